// File: rtl/mul8_err_pkg.sv
// Shared types and default widths for the 8-bit multiplier error monitor.
package mul8_err_pkg;

  localparam int N_BITS = 8;
  localparam int CNT_W  = 32;
  localparam int SUM_W  = 48;
  localparam int ED_W   = 2*N_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul8_err_datapath.sv
// Two-stage pipeline: captures an accepted sample, then derives the exact
// product, signed/absolute error distance and error flag.
module mul8_err_datapath
  import mul8_err_pkg::*;
#(
  parameter int N_BITS = mul8_err_pkg::N_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      xfer,
  input  logic [N_BITS-1:0]         a,
  input  logic [N_BITS-1:0]         b,
  input  logic [2*N_BITS-1:0]       o,
  output logic                      s1_valid,
  output logic                      s2_valid,
  output logic signed [2*N_BITS:0]  ed,
  output logic [2*N_BITS-1:0]       abs_ed,
  output logic                      err
);

  localparam int P_W = 2*N_BITS;

  logic [N_BITS-1:0]       a_q;
  logic [N_BITS-1:0]       b_q;
  logic [P_W-1:0]          o_q;
  logic [P_W-1:0]          exact_c;
  logic signed [P_W:0]     ed_c;
  logic [P_W-1:0]          abs_c;

  assign exact_c = {{N_BITS{1'b0}}, a_q} * {{N_BITS{1'b0}}, b_q};
  // One extra bit so both exact-below and exact-above cases stay representable.
  assign ed_c    = $signed({1'b0, exact_c}) - $signed({1'b0, o_q});
  assign abs_c   = ed_c[P_W] ? P_W'(-ed_c) : ed_c[P_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      o_q      <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        a_q <= a;
        b_q <= b;
        o_q <= o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      ed       <= '0;
      abs_ed   <= '0;
      err      <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        ed     <= ed_c;
        abs_ed <= abs_c;
        err    <= (ed_c != '0);
      end
    end
  end

endmodule

// File: rtl/mul8_err_monitor.sv
// Error-metric accumulator for approximate 8-bit multipliers: run control,
// accepted-sample counter and the count/sum/max accumulators.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until num_samples have been taken
// DRAIN | no more input; waiting for the pipeline to empty
// DONE  | totals stable; a new start re-arms
module mul8_err_monitor
  import mul8_err_pkg::*;
#(
  parameter int N_BITS = mul8_err_pkg::N_BITS,
  parameter int CNT_W  = mul8_err_pkg::CNT_W,
  parameter int SUM_W  = mul8_err_pkg::SUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_samples,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_BITS-1:0]       in_a,
  input  logic [N_BITS-1:0]       in_b,
  input  logic [2*N_BITS-1:0]     in_o,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sample_count,
  output logic [CNT_W-1:0]        err_count,
  output logic [SUM_W-1:0]        sum_abs_ed,
  output logic signed [SUM_W:0]   sum_ed,
  output logic [2*N_BITS-1:0]     max_abs_ed
);

  localparam int P_W  = 2*N_BITS;
  localparam int EDW  = 2*N_BITS + 1;

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     num_q;
  logic [CNT_W-1:0]     accepted;
  logic                 launch;
  logic                 xfer;
  logic                 s1_valid;
  logic                 s2_valid;
  logic signed [EDW-1:0] ed;
  logic [P_W-1:0]       abs_ed;
  logic                 err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (num_samples == '0) ? DONE : RUN;
      RUN:        if (accepted == num_q) state_nx = DRAIN;
      DRAIN:      if (!s1_valid && !s2_valid) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && (accepted < num_q);
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    launch   = start && ((state == IDLE) || (state == DONE));
  end

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q    <= '0;
      accepted <= '0;
    end else if (launch) begin
      num_q    <= num_samples;
      accepted <= '0;
    end else if (xfer) begin
      accepted <= accepted + CNT_W'(1);
    end
  end

  mul8_err_datapath #(.N_BITS(N_BITS)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .xfer     (xfer),
    .a        (in_a),
    .b        (in_b),
    .o        (in_o),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .ed       (ed),
    .abs_ed   (abs_ed),
    .err      (err)
  );

  // The pipeline is always empty when launch is honoured, so clear never races an update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
      err_count    <= '0;
      sum_abs_ed   <= '0;
      sum_ed       <= '0;
      max_abs_ed   <= '0;
    end else if (launch) begin
      sample_count <= '0;
      err_count    <= '0;
      sum_abs_ed   <= '0;
      sum_ed       <= '0;
      max_abs_ed   <= '0;
    end else if (s2_valid) begin
      sample_count <= sample_count + CNT_W'(1);
      err_count    <= err_count + {{(CNT_W-1){1'b0}}, err};
      sum_abs_ed   <= sum_abs_ed + {{(SUM_W-P_W){1'b0}}, abs_ed};
      sum_ed       <= sum_ed + $signed({{(SUM_W+1-EDW){ed[EDW-1]}}, ed});
      if (abs_ed > max_abs_ed) max_abs_ed <= abs_ed;
    end
  end

endmodule
